// File: rtl/dpd_tap_fanout8.sv
// Complex sample fan-out for the eight DPD actuator branches: tap k = x(n - k*S), S = tap_stride+1.
// Optional `DPD_FANOUT_ZERO_PAD_EN: emit every accepted sample, reading unfilled taps as zero.
module dpd_tap_fanout8 #(
  parameter int DWIDTH     = 16,
  parameter int MAX_STRIDE = 4,
  parameter int STRIDE_W   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [STRIDE_W-1:0]   tap_stride,
  input  logic                  din_enable,
  input  logic [2*DWIDTH-1:0]   din,
  output logic                  dout_valid,
  output logic [2*DWIDTH-1:0]   dout0,
  output logic [2*DWIDTH-1:0]   dout1,
  output logic [2*DWIDTH-1:0]   dout2,
  output logic [2*DWIDTH-1:0]   dout3,
  output logic [2*DWIDTH-1:0]   dout4,
  output logic [2*DWIDTH-1:0]   dout5,
  output logic [2*DWIDTH-1:0]   dout6,
  output logic [2*DWIDTH-1:0]   dout7,
  output logic                  warm
);

  localparam int SW    = 2 * DWIDTH;
  localparam int DEPTH = 7 * MAX_STRIDE + 1;
  localparam int CNT_W = $clog2(7 * MAX_STRIDE + 1);

  typedef enum logic [1:0] {ST_EMPTY, ST_FILL, ST_RUN} state_t;

  state_t              state, state_nxt;
  logic [STRIDE_W-1:0] stride_code;
  logic [CNT_W-1:0]    fill_cnt, fill_cnt_nxt, cnt_inc;
  logic [CNT_W-1:0]    span_cur;
  logic                stride_chg, valid_nxt;
  int                  s_new;

  logic [SW-1:0] hist    [DEPTH];
  logic [SW-1:0] taps_q  [8];
  logic [SW-1:0] tap_sel [8];

  // Codes beyond the largest supported spacing saturate rather than wrap.
  function automatic int stride_of(input logic [STRIDE_W-1:0] code);
    int s;
    s = int'(code) + 1;
    if (s > MAX_STRIDE) s = MAX_STRIDE;
    return s;
  endfunction

  assign s_new      = stride_of(tap_stride);
  assign span_cur   = CNT_W'(7 * stride_of(stride_code));
  assign stride_chg = (tap_stride != stride_code);
  assign cnt_inc    = fill_cnt + 1'b1;

  // Taps are picked from the pre-shift buffer with the stride in force after this edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    for (int k = 0; k < 8; k++) tap_sel[k] = '0;
    tap_sel[0] = din;
    for (int k = 1; k < 8; k++)
      for (int s = 1; s <= MAX_STRIDE; s++)
        if (s == s_new) tap_sel[k] = hist[k*s-1];
  end

  always_comb begin
    state_nxt    = state;
    fill_cnt_nxt = fill_cnt;
    valid_nxt    = 1'b0;
    if (din_enable) begin
      fill_cnt_nxt = (fill_cnt >= span_cur) ? fill_cnt : cnt_inc;
`ifdef DPD_FANOUT_ZERO_PAD_EN
      valid_nxt    = 1'b1;
`else
      valid_nxt    = (fill_cnt >= span_cur);
`endif
    end
    case (state)
      ST_EMPTY: if (din_enable) state_nxt = ST_FILL;
      ST_FILL:  if (din_enable && cnt_inc >= span_cur) state_nxt = ST_RUN;
      ST_RUN:   state_nxt = ST_RUN;
      default:  state_nxt = ST_EMPTY;
    endcase
    // A new stride restarts warm-up; a sample taken now is the first one under it.
    if (stride_chg) begin
      fill_cnt_nxt = din_enable ? CNT_W'(1) : '0;
      state_nxt    = din_enable ? ST_FILL : ST_EMPTY;
`ifdef DPD_FANOUT_ZERO_PAD_EN
      valid_nxt    = din_enable;
`else
      valid_nxt    = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    if (!rst_n) begin
      state       <= ST_EMPTY;
      fill_cnt    <= '0;
      stride_code <= '0;
      dout_valid  <= 1'b0;
    end else if (clear) begin
      state       <= ST_EMPTY;
      fill_cnt    <= '0;
      dout_valid  <= 1'b0;
    end else begin
      state       <= state_nxt;
      fill_cnt    <= fill_cnt_nxt;
      stride_code <= tap_stride;
      dout_valid  <= valid_nxt;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the history is deliberately reset so unfilled taps read as zero, not stale data.
    if (!rst_n || clear) begin
      for (int j = 0; j < DEPTH; j++) hist[j] <= '0;
      for (int k = 0; k < 8; k++) taps_q[k] <= '0;
    end else if (din_enable) begin
      hist[0] <= din;
      for (int j = 1; j < DEPTH; j++) hist[j] <= hist[j-1];
      for (int k = 0; k < 8; k++) taps_q[k] <= tap_sel[k];
    end
  end

  assign warm  = (state == ST_RUN);
  assign dout0 = taps_q[0];
  assign dout1 = taps_q[1];
  assign dout2 = taps_q[2];
  assign dout3 = taps_q[3];
  assign dout4 = taps_q[4];
  assign dout5 = taps_q[5];
  assign dout6 = taps_q[6];
  assign dout7 = taps_q[7];

endmodule
